// File: rtl/proc_mem_responder.sv
// proc_mem_responder: word memory serving imem fetch and dmem load/store, with a program load port that holds the processor in reset until loading finishes.
// Optional feature: define PROC_MEM_BOUNDS_EN to flag misaligned or out-of-range RUN accesses on err and suppress offending writes.
module proc_mem_responder #(
    parameter  int NUM_WORDS = 256,
    localparam int AW        = $clog2(NUM_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          imemreq_val,
    input  logic [31:0]   imemreq_addr,
    output logic [31:0]   imemresp_data,
    input  logic          dmemreq_val,
    input  logic          dmemreq_type,
    input  logic [31:0]   dmemreq_addr,
    input  logic [31:0]   dmemreq_wdata,
    output logic [31:0]   dmemresp_rdata,
    input  logic          load_val,
    output logic          load_rdy,
    input  logic [31:0]   load_data,
    input  logic          load_last,
    output logic          proc_go,
    output logic [AW:0]   load_count,
    output logic          err
);
`ifdef PROC_MEM_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    typedef enum logic {LOAD, RUN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] load_ptr_q, load_ptr_d;
    logic [AW:0]   load_count_q, load_count_d;
    logic          err_q, err_d;
    logic [31:0]   mem [NUM_WORDS];

    logic          run, accept, imem_bad, dmem_bad, dmem_wr, mem_we;
    logic [AW-1:0] imem_idx, dmem_idx, mem_waddr;
    logic [31:0]   mem_wdata;

    // Decode indices, address legality and the single shared write port
    always_comb begin
        run       = state_q == RUN;
        accept    = !run && load_val;
        imem_idx  = imemreq_addr[AW+1:2];
        dmem_idx  = dmemreq_addr[AW+1:2];
        imem_bad  = (imemreq_addr[1:0] != 2'b0) || (imemreq_addr[31:AW+2] != '0);
        dmem_bad  = (dmemreq_addr[1:0] != 2'b0) || (dmemreq_addr[31:AW+2] != '0);
        dmem_wr   = run && dmemreq_val && dmemreq_type && !(BOUNDS_EN && dmem_bad);
        mem_we    = accept || dmem_wr;
        mem_waddr = accept ? load_ptr_q : dmem_idx;
        mem_wdata = accept ? load_data : dmemreq_wdata;
    end

    // Next-state: load pointer advances per accepted word; last or full word enters RUN
    always_comb begin
        state_d      = (accept && (load_last || load_ptr_q == AW'(NUM_WORDS - 1))) ? RUN : state_q;
        load_ptr_d   = accept ? load_ptr_q + 1'b1 : load_ptr_q;
        load_count_d = accept ? load_count_q + 1'b1 : load_count_q;
        err_d        = err_q || (BOUNDS_EN && run &&
                       ((imemreq_val && imem_bad) || (dmemreq_val && dmem_bad)));
    end

    // Control state; memory contents are deliberately outside reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            load_ptr_q   <= '0;
            load_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_ptr_q   <= load_ptr_d;
            load_count_q <= load_count_d;
            err_q        <= err_d;
        end
    end

    // Word array write; reads below see the old value until the next cycle
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Zero-latency responses, gated to RUN and valid reads
    always_comb begin
        imemresp_data  = (run && imemreq_val) ? mem[imem_idx] : '0;
        dmemresp_rdata = (run && dmemreq_val && !dmemreq_type) ? mem[dmem_idx] : '0;
        load_rdy       = !run;
        proc_go        = run;
        load_count     = load_count_q;
        err            = err_q;
    end
endmodule

// File: tb/tb_proc_mem_responder.sv
// tb_proc_mem_responder: directed checks of loading, RUN access, reset and bounds behaviour.
module tb_proc_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imemreq_val = 1'b0;
    logic [31:0] imemreq_addr = '0;
    logic [31:0] imemresp_data;
    logic        dmemreq_val = 1'b0;
    logic        dmemreq_type = 1'b0;
    logic [31:0] dmemreq_addr = '0;
    logic [31:0] dmemreq_wdata = '0;
    logic [31:0] dmemresp_rdata;
    logic        load_val = 1'b0;
    logic        load_rdy;
    logic [31:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        proc_go;
    logic [8:0]  load_count;
    logic        err;
    int          passed = 0;
    int          total = 0;

    proc_mem_responder #(.NUM_WORDS(256)) dut (
        .clk(clk), .rst(rst),
        .imemreq_val(imemreq_val), .imemreq_addr(imemreq_addr), .imemresp_data(imemresp_data),
        .dmemreq_val(dmemreq_val), .dmemreq_type(dmemreq_type), .dmemreq_addr(dmemreq_addr),
        .dmemreq_wdata(dmemreq_wdata), .dmemresp_rdata(dmemresp_rdata),
        .load_val(load_val), .load_rdy(load_rdy), .load_data(load_data), .load_last(load_last),
        .proc_go(proc_go), .load_count(load_count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] d, input logic last);
        load_val = 1'b1; load_data = d; load_last = last;
        tick();
        load_val = 1'b0; load_last = 1'b0;
    endtask

    task automatic dmem_write(input logic [31:0] a, input logic [31:0] d);
        dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = a; dmemreq_wdata = d;
        tick();
        dmemreq_val = 1'b0; dmemreq_type = 1'b0;
    endtask

    task automatic imem_read(input logic [31:0] a, output logic [31:0] d);
        imemreq_val = 1'b1; imemreq_addr = a;
        #1;
        d = imemresp_data;
        imemreq_val = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        total++; if (load_rdy !== 1'b1) $display("FAIL reset_load_rdy got=%0b exp=1", load_rdy); else passed++;
        total++; if (proc_go !== 1'b0) $display("FAIL reset_proc_go got=%0b exp=0", proc_go); else passed++;
        total++; if (load_count !== 9'd0) $display("FAIL reset_load_count got=%0d exp=0", load_count); else passed++;
        total++; if (err !== 1'b0) $display("FAIL reset_err got=%0b exp=0", err); else passed++;
        imem_read(32'h0, d);
        total++; if (d !== 32'h0) $display("FAIL reset_imem_resp got=%h exp=0", d); else passed++;
    endtask

    task automatic test_load_program();
        logic [31:0] d;
        load_word(32'h11, 1'b0);
        load_word(32'h22, 1'b0);
        load_word(32'h33, 1'b0);
        total++; if (proc_go !== 1'b0) $display("FAIL load3_proc_go got=%0b exp=0", proc_go); else passed++;
        total++; if (load_count !== 9'd3) $display("FAIL load3_count got=%0d exp=3", load_count); else passed++;
        load_word(32'h44, 1'b1);
        total++; if (load_count !== 9'd4) $display("FAIL load4_count got=%0d exp=4", load_count); else passed++;
        total++; if (proc_go !== 1'b1) $display("FAIL load4_proc_go got=%0b exp=1", proc_go); else passed++;
        total++; if (load_rdy !== 1'b0) $display("FAIL load4_load_rdy got=%0b exp=0", load_rdy); else passed++;
        imem_read(32'h8, d);
        total++; if (d !== 32'h33) $display("FAIL imem_0x8 got=%h exp=33", d); else passed++;
        load_word(32'h99, 1'b1);
        total++; if (load_count !== 9'd4) $display("FAIL run_ignores_load got=%0d exp=4", load_count); else passed++;
    endtask

    task automatic test_run_write_read();
        dmem_write(32'h10, 32'h12345678);
        dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h10; dmemreq_wdata = 32'hDEADBEEF;
        imemreq_val = 1'b1; imemreq_addr = 32'h10;
        #1;
        total++; if (imemresp_data !== 32'h12345678) $display("FAIL same_cycle_old got=%h exp=12345678", imemresp_data); else passed++;
        total++; if (dmemresp_rdata !== 32'h0) $display("FAIL write_cycle_rdata got=%h exp=0", dmemresp_rdata); else passed++;
        tick();
        dmemreq_type = 1'b0;
        #1;
        total++; if (dmemresp_rdata !== 32'hDEADBEEF) $display("FAIL dmem_next_cycle got=%h exp=deadbeef", dmemresp_rdata); else passed++;
        total++; if (imemresp_data !== 32'hDEADBEEF) $display("FAIL imem_next_cycle got=%h exp=deadbeef", imemresp_data); else passed++;
        dmemreq_val = 1'b0; imemreq_val = 1'b0;
        #1;
        total++; if (imemresp_data !== 32'h0) $display("FAIL imem_no_val got=%h exp=0", imemresp_data); else passed++;
    endtask

    task automatic test_full_load();
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 255; i++) load_word(32'h1000 + i, 1'b0);
        total++; if (proc_go !== 1'b0) $display("FAIL full255_proc_go got=%0b exp=0", proc_go); else passed++;
        load_word(32'h10FF, 1'b0);
        total++; if (proc_go !== 1'b1) $display("FAIL full256_proc_go got=%0b exp=1", proc_go); else passed++;
        total++; if (load_count !== 9'd256) $display("FAIL full256_count got=%0d exp=256", load_count); else passed++;
        load_word(32'hFFFF, 1'b0);
        total++; if (load_count !== 9'd256) $display("FAIL full257_count got=%0d exp=256", load_count); else passed++;
        imem_read(32'h3FC, d);
        total++; if (d !== 32'h10FF) $display("FAIL full_last_word got=%h exp=10ff", d); else passed++;
        imem_read(32'h0, d);
        total++; if (d !== 32'h1000) $display("FAIL full_first_word got=%h exp=1000", d); else passed++;
    endtask

    task automatic test_mid_load_reset();
        logic [31:0] d;
        do_reset();
        load_word(32'hB1, 1'b0);
        load_word(32'hB2, 1'b0);
        total++; if (load_count !== 9'd2) $display("FAIL midrst_pre_count got=%0d exp=2", load_count); else passed++;
        do_reset();
        total++; if (load_count !== 9'd0) $display("FAIL midrst_count got=%0d exp=0", load_count); else passed++;
        total++; if (proc_go !== 1'b0) $display("FAIL midrst_proc_go got=%0b exp=0", proc_go); else passed++;
        load_word(32'hAA, 1'b1);
        total++; if (proc_go !== 1'b1) $display("FAIL reload_proc_go got=%0b exp=1", proc_go); else passed++;
        imem_read(32'h0, d);
        total++; if (d !== 32'hAA) $display("FAIL reload_mem0 got=%h exp=aa", d); else passed++;
        imem_read(32'h4, d);
        total++; if (d !== 32'hB2) $display("FAIL reload_mem1 got=%h exp=b2", d); else passed++;
    endtask

    task automatic test_load_ignores_dmem();
        logic [31:0] d;
        do_reset();
        load_word(32'h66, 1'b0);
        dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h0; dmemreq_wdata = 32'hBAD;
        imemreq_val = 1'b1; imemreq_addr = 32'h0;
        #1;
        total++; if (imemresp_data !== 32'h0) $display("FAIL load_imem_resp got=%h exp=0", imemresp_data); else passed++;
        tick();
        dmemreq_type = 1'b0;
        #1;
        total++; if (dmemresp_rdata !== 32'h0) $display("FAIL load_dmem_resp got=%h exp=0", dmemresp_rdata); else passed++;
        dmemreq_val = 1'b0; imemreq_val = 1'b0;
        load_word(32'h67, 1'b1);
        imem_read(32'h0, d);
        total++; if (d !== 32'h66) $display("FAIL load_write_ignored got=%h exp=66", d); else passed++;
        total++; if (load_count !== 9'd2) $display("FAIL load_ign_count got=%0d exp=2", load_count); else passed++;
    endtask

    task automatic test_bounds();
        logic [31:0] d;
        dmem_write(32'h402, 32'hCAFEF00D);
        imem_read(32'h0, d);
`ifdef PROC_MEM_BOUNDS_EN
        total++; if (err !== 1'b1) $display("FAIL bounds_err got=%0b exp=1", err); else passed++;
        total++; if (d !== 32'h66) $display("FAIL bounds_suppressed got=%h exp=66", d); else passed++;
        tick(); tick(); tick();
        total++; if (err !== 1'b1) $display("FAIL bounds_err_held got=%0b exp=1", err); else passed++;
`else
        total++; if (err !== 1'b0) $display("FAIL bounds_err got=%0b exp=0", err); else passed++;
        total++; if (d !== 32'hCAFEF00D) $display("FAIL bounds_wrap_write got=%h exp=cafef00d", d); else passed++;
`endif
        do_reset();
        total++; if (err !== 1'b0) $display("FAIL bounds_err_rst got=%0b exp=0", err); else passed++;
    endtask

    initial begin
        test_reset();
        test_load_program();
        test_run_write_read();
        test_full_load();
        test_mid_load_reset();
        test_load_ignores_dmem();
        test_bounds();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
